// File: rtl/mux_nx1_fp_pipe_pkg.sv
// mux_pkg: shared constants and helpers for the FP operand selector
package mux_pkg;
    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int FIFO_DEPTH = 2;
    function automatic int clog2_min1(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/mux_nx1_fp_pipe_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant starting after the last winner
module rr_arbiter import mux_pkg::*; #(
    parameter  int N     = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    input  logic             adv,
    output logic [N-1:0]     grant_oh,
    output logic [SEL_W-1:0] grant_idx
);
    // Scan farthest-first so the closest requester after ptr overwrites and wins
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (adv && req[(int'(ptr) + k) % N]) begin
                grant_oh                          = '0;
                grant_oh[(int'(ptr) + k) % N]     = 1'b1;
                grant_idx                         = SEL_W'((int'(ptr) + k) % N);
            end
        end
    end
endmodule

// File: rtl/mux_nx1_fp_pipe.sv
// mux_nx1_fp_pipe: registered N:1 FP field selector with 2-entry output skid FIFO
module mux_nx1_fp_pipe import mux_pkg::*; #(
    parameter  int WIDTH = 23,
    parameter  int N     = 4,
    parameter  int MODE  = MODE_FIXED,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src
);
    logic [WIDTH-1:0] r_mem_d [FIFO_DEPTH];
    logic [SEL_W-1:0] r_mem_s [FIFO_DEPTH];
    logic             r_wr;
    logic             r_rd;
    logic [1:0]       r_cnt;
    logic [WIDTH-1:0] r_last_d;
    logic [SEL_W-1:0] r_last_s;
    logic             w_space;
    logic             w_push;
    logic             w_pop;
    logic [N-1:0]     w_grant_oh;
    logic [SEL_W-1:0] w_grant_idx;
    logic [WIDTH-1:0] w_push_d;

    // Gating with rst_n keeps in_ready low for the whole time reset is held
    assign w_space = rst_n && (r_cnt < 2'(FIFO_DEPTH));

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic [SEL_W-1:0] r_ptr;
            logic             w_unused_sel;
            assign w_unused_sel = ^sel;
            rr_arbiter #(.N(N)) u_arb (
                .req       (in_valid),
                .ptr       (r_ptr),
                .adv       (w_space),
                .grant_oh  (w_grant_oh),
                .grant_idx (w_grant_idx)
            );
            // Last accepted channel becomes lowest priority; reset gives ch0 first turn
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      r_ptr <= SEL_W'(N - 1);
                else if (w_push) r_ptr <= w_grant_idx;
            end
        end else begin : g_fix
            // An out-of-range sel matches no channel and therefore grants nothing
            always_comb begin
                w_grant_oh = '0;
                for (int i = 0; i < N; i++)
                    w_grant_oh[i] = w_space && in_valid[i] && (int'(sel) == i);
            end
            assign w_grant_idx = sel;
        end
    endgenerate

    assign in_ready  = w_grant_oh;
    assign w_push    = |(in_valid & in_ready);
    assign out_valid = (r_cnt != 2'd0);
    assign w_pop     = out_valid & out_ready;
    assign out_data  = out_valid ? r_mem_d[r_rd] : r_last_d;
    assign out_src   = out_valid ? r_mem_s[r_rd] : r_last_s;

    // Route the granted channel's word to the FIFO tail
    always_comb begin
        w_push_d = '0;
        for (int i = 0; i < N; i++)
            if (w_grant_oh[i]) w_push_d = in_data[i*WIDTH +: WIDTH];
    end

    // Two-slot ring; the last popped head is kept so outputs hold while empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_d  <= '{default: '0};
            r_mem_s  <= '{default: '0};
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_cnt    <= 2'd0;
            r_last_d <= '0;
            r_last_s <= '0;
        end else begin
            if (w_push) begin
                r_mem_d[r_wr] <= w_push_d;
                r_mem_s[r_wr] <= w_grant_idx;
                r_wr          <= ~r_wr;
            end
            if (w_pop) begin
                r_rd     <= ~r_rd;
                r_last_d <= out_data;
                r_last_s <= out_src;
            end
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
        end
    end
endmodule
